// File: rtl/cinema_pkg.sv
// cinema_pkg: shared geometry, pricing enums and price constants for the cinema engine
package cinema_pkg;
   localparam int NUM_THEATERS      = 4;
   localparam int NUM_ROWS          = 10;
   localparam int NUM_COLS          = 10;
   localparam int SEATS_PER_THEATER = NUM_ROWS * NUM_COLS;
   localparam int TOTAL_SEATS       = NUM_THEATERS * SEATS_PER_THEATER;

   typedef logic [8:0] price_t;

   typedef enum logic [1:0] {CAT_STANDARD, CAT_PREMIUM, CAT_VIP, CAT_RECLINER} seat_cat_e;
   typedef enum logic [1:0] {SLOT_MATINEE, SLOT_AFTERNOON, SLOT_EVENING, SLOT_NIGHT} time_slot_e;
   typedef enum logic [2:0] {DAY_WEEKDAY, DAY_WEEKEND, DAY_HOLIDAY, DAY_DISCOUNT} day_type_e;

   localparam price_t BASE_STANDARD = 9'd100;
   localparam price_t BASE_PREMIUM  = 9'd150;
   localparam price_t BASE_VIP      = 9'd200;
   localparam price_t BASE_RECLINER = 9'd250;

   // negative adjustments are two's complement; the 9-bit wrap-around sum stays exact
   localparam price_t ADJ_MATINEE   = 9'(-20);
   localparam price_t ADJ_AFTERNOON = 9'd0;
   localparam price_t ADJ_EVENING   = 9'd30;
   localparam price_t ADJ_NIGHT     = 9'd20;

   localparam price_t ADJ_WEEKDAY   = 9'd0;
   localparam price_t ADJ_WEEKEND   = 9'd50;
   localparam price_t ADJ_HOLIDAY   = 9'd80;
   localparam price_t ADJ_DISCOUNT  = 9'(-30);
endpackage

// File: rtl/cinema_pricer.sv
// cinema_pricer: combinational ticket price from seat category, time slot and day type
module cinema_pricer
   import cinema_pkg::*;
(
   input  logic [1:0] seat_category,
   input  logic [1:0] time_slot,
   input  logic [2:0] day_type,
   output price_t     price
);
   price_t base, time_adj, day_adj;

   // day codes 4..7 fall through to the weekday adjustment
   always_comb begin
      base     = seat_category == CAT_STANDARD ? BASE_STANDARD :
                 seat_category == CAT_PREMIUM  ? BASE_PREMIUM  :
                 seat_category == CAT_VIP      ? BASE_VIP      : BASE_RECLINER;
      time_adj = time_slot == SLOT_MATINEE   ? ADJ_MATINEE   :
                 time_slot == SLOT_AFTERNOON ? ADJ_AFTERNOON :
                 time_slot == SLOT_EVENING   ? ADJ_EVENING   : ADJ_NIGHT;
      day_adj  = day_type == DAY_WEEKEND  ? ADJ_WEEKEND  :
                 day_type == DAY_HOLIDAY  ? ADJ_HOLIDAY  :
                 day_type == DAY_DISCOUNT ? ADJ_DISCOUNT : ADJ_WEEKDAY;
      price    = base + time_adj + day_adj;
   end
endmodule

// File: rtl/cinema_system.sv
// cinema_system: seat reservation, per-seat sold price memory and revenue tracking for four theaters
module cinema_system
   import cinema_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  theater_id,
   input  logic [3:0]  row,
   input  logic [3:0]  col,
   input  logic        book_seat,
   input  logic        cancel_seat,
   input  logic [1:0]  seat_category,
   input  logic [1:0]  time_slot,
   input  logic [2:0]  day_type,
   output logic [7:0]  seat_status_out,
   output logic [7:0]  total_booked,
   output logic [7:0]  total_available,
   output logic [15:0] revenue,
   output logic [15:0] total_revenue
);
   logic [TOTAL_SEATS-1:0] occ_q, occ_d;
   price_t                 price_q [TOTAL_SEATS];
   price_t                 price_d [TOTAL_SEATS];
   logic [6:0]             cnt_q [NUM_THEATERS];
   logic [6:0]             cnt_d [NUM_THEATERS];
   logic [15:0]            revenue_q, revenue_d, total_revenue_q, total_revenue_d;
   price_t                 price, stored;
   logic [8:0]             idx;
   logic [16:0]            sum;
   logic                   addr_valid, seat_booked, do_book, do_cancel;

   cinema_pricer u_pricer (
      .seat_category (seat_category),
      .time_slot     (time_slot),
      .day_type      (day_type),
      .price         (price)
   );

   // decode the addressed seat and apply at most one successful book or cancel
   always_comb begin
      addr_valid      = row < 4'(NUM_ROWS) && col < 4'(NUM_COLS);
      idx             = addr_valid ? 9'(theater_id) * 9'(SEATS_PER_THEATER) + 9'(row) * 9'(NUM_COLS) + 9'(col) : '0;
      seat_booked     = occ_q[idx];
      stored          = price_q[idx];
      do_book         = book_seat && !cancel_seat && addr_valid && !seat_booked;
      do_cancel       = cancel_seat && !book_seat && addr_valid && seat_booked;
      sum             = {1'b0, total_revenue_q} + 17'(price);
      occ_d           = occ_q;
      price_d         = price_q;
      cnt_d           = cnt_q;
      revenue_d       = revenue_q;
      total_revenue_d = total_revenue_q;
      if (do_book) begin
         occ_d[idx]          = 1'b1;
         price_d[idx]        = price;
         cnt_d[theater_id]   = cnt_q[theater_id] + 7'd1;
         revenue_d           = 16'(price);
         total_revenue_d     = sum[16] ? 16'hffff : sum[15:0];
      end else if (do_cancel) begin
         occ_d[idx]          = 1'b0;
         price_d[idx]        = '0;
         cnt_d[theater_id]   = cnt_q[theater_id] - 7'd1;
         revenue_d           = 16'(stored);
         total_revenue_d     = total_revenue_q < 16'(stored) ? 16'd0 : total_revenue_q - 16'(stored);
      end
   end

   // seat arrays, theater counters and revenue registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q           <= '0;
         for (int i = 0; i < TOTAL_SEATS; i++) price_q[i] <= '0;
         for (int i = 0; i < NUM_THEATERS; i++) cnt_q[i] <= '0;
         revenue_q       <= '0;
         total_revenue_q <= '0;
      end else begin
         occ_q           <= occ_d;
         price_q         <= price_d;
         cnt_q           <= cnt_d;
         revenue_q       <= revenue_d;
         total_revenue_q <= total_revenue_d;
      end
   end

   // status of the addressed seat and occupancy of the selected theater
   always_comb begin
      seat_status_out = addr_valid ? {7'd0, seat_booked} : 8'd2;
      total_booked    = {1'b0, cnt_q[theater_id]};
      total_available = 8'(SEATS_PER_THEATER) - total_booked;
      revenue         = revenue_q;
      total_revenue   = total_revenue_q;
   end
endmodule

// File: tb/tb_cinema_system.sv
// tb_cinema_system: scoreboard bench for cinema_system against an independent seat/price model
module tb_cinema_system;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  theater_id = '0;
   logic [3:0]  row = '0;
   logic [3:0]  col = '0;
   logic        book_seat = 1'b0;
   logic        cancel_seat = 1'b0;
   logic [1:0]  seat_category = '0;
   logic [1:0]  time_slot = '0;
   logic [2:0]  day_type = '0;
   logic [7:0]  seat_status_out, total_booked, total_available;
   logic [15:0] revenue, total_revenue;

   typedef struct {
      logic [55:0] v;
      string       name;
   } exp_t;

   exp_t        sb [$];
   logic [55:0] obs_q [$];
   int          checks = 0;
   int          errors = 0;

   bit m_occ   [400];
   int m_price [400];
   int m_cnt   [4];
   int m_rev, m_tot;

   cinema_system dut (
      .clk             (clk),
      .reset           (reset),
      .theater_id      (theater_id),
      .row             (row),
      .col             (col),
      .book_seat       (book_seat),
      .cancel_seat     (cancel_seat),
      .seat_category   (seat_category),
      .time_slot       (time_slot),
      .day_type        (day_type),
      .seat_status_out (seat_status_out),
      .total_booked    (total_booked),
      .total_available (total_available),
      .revenue         (revenue),
      .total_revenue   (total_revenue)
   );

   always #5 clk = ~clk;

   function automatic int ref_price(input int cat, input int slot, input int day);
      int b, t, d;
      case (cat)
         0: b = 100;
         1: b = 150;
         2: b = 200;
         default: b = 250;
      endcase
      case (slot)
         0: t = -20;
         1: t = 0;
         2: t = 30;
         default: t = 20;
      endcase
      case (day)
         1: d = 50;
         2: d = 80;
         3: d = -30;
         default: d = 0;
      endcase
      return b + t + d;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 400; i++) begin
         m_occ[i]   = 1'b0;
         m_price[i] = 0;
      end
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_rev = 0;
      m_tot = 0;
   endtask

   task automatic cmd(input int t, input int r, input int c, input bit b, input bit x,
                      input int cat, input int slot, input int day, input string name);
      bit v;
      int i, p;
      theater_id    = 2'(t);
      row           = 4'(r);
      col           = 4'(c);
      book_seat     = b;
      cancel_seat   = x;
      seat_category = 2'(cat);
      time_slot     = 2'(slot);
      day_type      = 3'(day);
      v = r < 10 && c < 10;
      i = v ? t * 100 + r * 10 + c : 0;
      p = ref_price(cat, slot, day);
      if (b && !x && v && !m_occ[i]) begin
         m_occ[i]   = 1'b1;
         m_price[i] = p;
         m_cnt[t]++;
         m_rev = p;
         m_tot = m_tot + p > 65535 ? 65535 : m_tot + p;
      end else if (x && !b && v && m_occ[i]) begin
         m_occ[i] = 1'b0;
         m_cnt[t]--;
         m_rev = m_price[i];
         m_tot = m_tot < m_price[i] ? 0 : m_tot - m_price[i];
         m_price[i] = 0;
      end
      sb.push_back('{{8'(v ? int'(m_occ[i]) : 2), 8'(m_cnt[t]), 8'(100 - m_cnt[t]), 16'(m_rev), 16'(m_tot)}, name});
      @(posedge clk);
      #1;
      book_seat   = 1'b0;
      cancel_seat = 1'b0;
      obs_q.push_back({seat_status_out, total_booked, total_available, revenue, total_revenue});
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [55:0] o;
      model_clear();
      reset = 1'b0;
      #12;
      checks++;
      if ({seat_status_out, total_booked, total_available, revenue, total_revenue} !== {8'd0, 8'd0, 8'd100, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL in_reset: got %h want %h", {seat_status_out, total_booked, total_available, revenue, total_revenue}, {8'd0, 8'd0, 8'd100, 16'd0, 16'd0});
      end
      @(negedge clk);
      reset = 1'b1;
      cmd(0, 0, 0, 0, 0, 0, 0, 0, "idle_t0r0c0");
      cmd(0, 12, 3, 0, 0, 0, 0, 0, "invalid_row12");
      cmd(3, 9, 9, 0, 0, 0, 0, 0, "idle_t3r9c9");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_book();
      exp_t        e;
      logic [55:0] o;
      cmd(1, 2, 3, 1, 0, 1, 2, 1, "book_t1r2c3");
      cmd(0, 2, 3, 0, 0, 0, 0, 0, "peek_t0");
      cmd(1, 2, 3, 1, 0, 3, 2, 1, "double_book");
      cmd(1, 0, 0, 1, 0, 0, 0, 3, "book_t1r0c0");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_cancel();
      exp_t        e;
      logic [55:0] o;
      cmd(1, 2, 3, 0, 1, 2, 3, 6, "cancel_t1r2c3");
      cmd(1, 5, 5, 0, 1, 1, 1, 1, "cancel_free");
      cmd(1, 0, 0, 1, 1, 2, 2, 2, "book_and_cancel");
      cmd(1, 10, 0, 1, 0, 1, 1, 1, "book_row10");
      cmd(2, 3, 15, 1, 0, 1, 1, 1, "book_col15");
      cmd(0, 9, 9, 1, 0, 2, 3, 7, "book_day7");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_held_command();
      exp_t        e;
      logic [55:0] o;
      for (int k = 0; k < 3; k++) cmd(2, 4, 4, 1, 0, 2, 1, 2, "held_book");
      for (int k = 0; k < 3; k++) cmd(2, 4, 4, 0, 1, 0, 0, 0, "held_cancel");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_random();
      exp_t        e;
      logic [55:0] o;
      for (int k = 0; k < 120; k++)
         cmd($urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), "random");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_saturate_floor();
      exp_t        e;
      logic [55:0] o;
      for (int t = 2; t < 4; t++)
         for (int s = 0; s < 100; s++) cmd(t, s / 10, s % 10, 1, 0, 3, 2, 2, "fill_saturate");
      for (int t = 2; t < 4; t++)
         for (int s = 0; s < 100; s++) cmd(t, s / 10, s % 10, 0, 1, 0, 0, 0, "drain_floor");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      logic [55:0] o;
      cmd(0, 1, 1, 1, 0, 1, 1, 1, "pre_reset_book_a");
      cmd(0, 1, 2, 1, 0, 2, 2, 2, "pre_reset_book_b");
      cmd(0, 1, 1, 0, 0, 0, 0, 0, "pre_reset_peek");
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({seat_status_out, total_booked, total_available, revenue, total_revenue} !== {8'd0, 8'd0, 8'd100, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL async_reset: got %h want %h", {seat_status_out, total_booked, total_available, revenue, total_revenue}, {8'd0, 8'd0, 8'd100, 16'd0, 16'd0});
      end
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      cmd(0, 1, 2, 0, 0, 0, 0, 0, "post_reset_peek");
      cmd(0, 1, 2, 0, 1, 0, 0, 0, "post_reset_cancel");
      cmd(0, 1, 2, 1, 0, 0, 1, 0, "post_reset_book");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h (status,booked,avail,rev,total)", e.name, o, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_book();
      test_cancel();
      test_held_command();
      test_random();
      test_saturate_floor();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cinema_system.md
Name: cinema_system

Overview:
Seat-reservation and pricing engine for a 4-theater cinema, each theater a 10x10 seat grid. It accepts single-cycle book and cancel commands addressed by theater/row/col. It tracks per-seat occupancy and the price each seat was sold at, and reports the addressed seat's status, the selected theater's occupancy, the last transaction amount and cumulative revenue.

Parameters:
NUM_THEATERS, 4, theaters addressed by theater_id
NUM_ROWS, 10, valid rows 0..9
NUM_COLS, 10, valid cols 0..9

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
theater_id  in  2  theater select
row  in  4  seat row
col  in  4  seat column
book_seat  in  1  book the addressed seat on this edge
cancel_seat  in  1  cancel the addressed seat on this edge
seat_category  in  2  0 standard, 1 premium, 2 VIP, 3 recliner
time_slot  in  2  0 matinee, 1 afternoon, 2 evening, 3 night
day_type  in  3  0 weekday, 1 weekend, 2 holiday, 3 discount day, 4-7 treated as weekday
seat_status_out  out  8  addressed seat: 0 free, 1 booked, 2 invalid address
total_booked  out  8  booked seats in selected theater, 0..100
total_available  out  8  100 - total_booked
revenue  out  16  amount of last successful transaction
total_revenue  out  16  cumulative net revenue, all theaters

Behaviour:
- Reset (reset=0, async):
  - All seats free; stored prices 0.
  - Per-theater booked counters 0.
  - revenue=0, total_revenue=0.
- Address valid iff row<10 and col<10. theater_id is always valid.
- Price is combinational, 9 bits unsigned: base + time adj + day adj.
  - base: 100 / 150 / 200 / 250 by seat_category.
  - time adj: -20 / 0 / +30 / +20 by time_slot.
  - day adj: 0 / +50 / +80 / -30 by day_type 0..3; day_type 4-7 adds 0.
  - Range 50..360.
- Commands are level-sampled at each rising edge. book_seat and cancel_seat high together: no operation.
- Book (book_seat=1, cancel_seat=0) succeeds only when the address is valid and the seat is free. On success:
  - mark seat booked;
  - store price in the per-seat 9-bit price memory;
  - increment the theater counter;
  - revenue <= price;
  - total_revenue <= total_revenue + price, saturating at 65535.
- Cancel (cancel_seat=1, book_seat=0) succeeds only when the address is valid and the seat is booked. On success:
  - mark seat free;
  - decrement the theater counter;
  - revenue <= stored price;
  - total_revenue <= total_revenue - stored price, floored at 0;
  - clear stored price.
- Rejected commands (invalid address, double book, cancel of a free seat) change no state, including revenue.
- A command held high for several cycles acts once: later edges are rejected as double book or free-seat cancel.
- Outputs:
  - seat_status_out, total_booked, total_available: combinational from current inputs and registered state. They reflect the post-edge state one cycle after a command.
  - revenue, total_revenue: registered.
  - Counters zero-extended to 8 bits.
- Storage: 4x100 occupancy bits plus 4x100x9 price bits, as flops or a register array. Index = theater*100 + row*10 + col.

Decomposition:
- Shared package cinema_pkg:
  - NUM_THEATERS, NUM_ROWS, NUM_COLS, SEATS_PER_THEATER=100;
  - category/time/day enum typedefs;
  - base-price and adjustment constants.
- One sub-module, cinema_pricer: pure combinational, maps (seat_category, time_slot, day_type) to a 9-bit price.
- Top holds the seat arrays, counters and revenue accumulators.

Test Plan:
- Reset, then release: all outputs 0 except total_available=100. Any valid seat reads seat_status_out=0. theater 0, row 12, col 3 -> seat_status_out=2.
- Book T1 R2 C3 with cat 1, slot 2, day 1 -> next cycle status=1, total_booked=1, total_available=99, revenue=230, total_revenue=230. Select theater 0 -> total_booked=0.
- Book the same seat again with cat 3 -> rejected: revenue=230, total_revenue=230, total_booked=1.
- Book T1 R0 C0 with cat 0, slot 0, day 3 -> revenue=50, total_revenue=280. Cancel T1 R2 C3 with any inputs -> revenue=230, total_revenue=50, total_booked=1, status=0.
- Cancel a free seat, or assert book and cancel together -> no change. Book row=10 -> status=2, no change.
- Assert reset mid-operation after several bookings -> immediately all seats free, counters 0, revenue=0, total_revenue=0.
